// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive packet framer: FSM state encoding,
// err_code values, the default start-of-frame marker and the modulo-256
// checksum helper.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_LEN     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_CSUM    = 2'd3;

    typedef enum logic [1:0] {
        HUNT    = ST_HUNT,
        LEN     = ST_LEN,
        PAYLOAD = ST_PAYLOAD,
        CSUM    = ST_CSUM
    } pkt_state_t;

    localparam logic [1:0] ERR_CSUM    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // Running checksum: plain 8-bit add, carry discarded.
    function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/uart_rx_pkt_timeout.sv
// -----------------------------------------------------------------------------
// uart_rx_pkt_timeout
// Inter-byte timeout counter for the packet framer. Only instantiated when
// UART_RX_PKT_TIMEOUT_EN is defined.
// Ports:
//   clk     in  1  system clock
//   reset   in  1  synchronous, active-high reset
//   clear   in  1  a byte is captured this cycle: restart the count
//   run     in  1  framer is inside a frame (busy)
//   freeze  in  1  consumer backpressure: hold the count
//   expire  out 1  count reached TIMEOUT_CYCLES-1 this cycle
// -----------------------------------------------------------------------------
module uart_rx_pkt_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    input  logic freeze,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Idle or freshly captured byte restarts the count; backpressure holds it.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear || !run) begin
            count <= '0;
        end else if (freeze) begin
            count <= count;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign expire = run && !clear && !freeze && (count == LAST);

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_pkt_ctrl
// Pops bytes from the UART RX FIFO and frames them as SOF, LEN, LEN payload
// bytes, CSUM. Payload is streamed over valid/ready; each frame ends with a
// one-cycle pkt_ok or pkt_err pulse. The checksum covers LEN, payload and
// CSUM and must total 8'h00 modulo 256.
// Optional feature: define UART_RX_PKT_TIMEOUT_EN to add an inter-byte
// timeout (err_code 2) and the TIMEOUT_CYCLES parameter.
// Ports:
//   clk        in  1  system clock
//   reset      in  1  synchronous, active-high reset
//   rx_rdy     in  1  RX FIFO not empty
//   rx_data    in  8  FIFO read data, valid the cycle after next_rx
//   next_rx    out 1  one-cycle FIFO pop strobe
//   pkt_data   out 8  payload byte
//   pkt_valid  out 1  pkt_data valid
//   pkt_ready  in  1  consumer accepts on pkt_valid && pkt_ready
//   pkt_last   out 1  final payload byte of the frame
//   pkt_ok     out 1  pulse: frame complete, checksum good
//   pkt_err    out 1  pulse: frame aborted or bad checksum
//   err_code   out 2  reason for pkt_err; holds between errors
//   busy       out 1  high whenever the FSM is not hunting for SOF
// -----------------------------------------------------------------------------
module uart_rx_pkt_ctrl
    import uart_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE = SOF_DEFAULT,
    parameter int         MAX_LEN  = 64
`ifdef UART_RX_PKT_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       next_rx,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic       pkt_last,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    pkt_state_t state;
    logic       cap;        // rx_data holds the byte popped last cycle
    logic [7:0] sum;
    logic [7:0] remaining;
    logic       accept;
    logic       need_byte;
    logic       pop_go;
    logic       expire;

    assign accept = pkt_valid && pkt_ready;

`ifdef UART_RX_PKT_TIMEOUT_EN
    uart_rx_pkt_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (cap),
        .run    (busy),
        .freeze (pkt_valid && !pkt_ready),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // Whether the current state wants another byte. In PAYLOAD the held byte
    // must be accepted first, so an accept this cycle unblocks the next pop.
    always_comb begin
        need_byte = 1'b0;
        case (state)
            HUNT, LEN, CSUM: need_byte = 1'b1;
            PAYLOAD:         need_byte = !pkt_valid || pkt_ready;
            default:         need_byte = 1'b0;
        endcase
    end

    // A pop is outstanding from the strobe cycle until the capture cycle.
    assign pop_go = rx_rdy && need_byte && !next_rx && !cap && !expire;

    // Framer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            cap       <= 1'b0;
            sum       <= 8'h00;
            remaining <= 8'h00;
            next_rx   <= 1'b0;
            pkt_data  <= 8'h00;
            pkt_valid <= 1'b0;
            pkt_last  <= 1'b0;
            pkt_ok    <= 1'b0;
            pkt_err   <= 1'b0;
            err_code  <= 2'd0;
            busy      <= 1'b0;
        end else begin
            next_rx <= pop_go;
            cap     <= next_rx;
            pkt_ok  <= 1'b0;
            pkt_err <= 1'b0;
            if (expire) begin
                // Abandon the frame, including any byte the consumer still holds.
                state     <= HUNT;
                busy      <= 1'b0;
                pkt_err   <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                pkt_valid <= 1'b0;
                pkt_last  <= 1'b0;
            end else if (accept) begin
                pkt_valid <= 1'b0;
                pkt_last  <= 1'b0;
                remaining <= remaining - 8'd1;
                if (remaining == 8'd1) begin
                    state <= CSUM;
                end else begin
                    state <= PAYLOAD;
                end
            end else if (cap) begin
                case (state)
                    HUNT: begin
                        if (rx_data == SOF_BYTE) begin
                            state <= LEN;
                            busy  <= 1'b1;
                        end else begin
                            state <= HUNT;
                        end
                    end
                    LEN: begin
                        sum       <= rx_data;
                        remaining <= rx_data;
                        if (rx_data == 8'd0) begin
                            state <= CSUM;
                        end else if (rx_data > MAX_LEN_B) begin
                            state    <= HUNT;
                            busy     <= 1'b0;
                            pkt_err  <= 1'b1;
                            err_code <= ERR_LEN;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        pkt_data  <= rx_data;
                        pkt_valid <= 1'b1;
                        pkt_last  <= (remaining == 8'd1);
                        sum       <= csum_add(sum, rx_data);
                    end
                    CSUM: begin
                        if (csum_add(sum, rx_data) == 8'h00) begin
                            pkt_ok <= 1'b1;
                        end else begin
                            pkt_err  <= 1'b1;
                            err_code <= ERR_CSUM;
                        end
                        state <= HUNT;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= HUNT;
                        busy  <= 1'b0;
                    end
                endcase
            end else begin
                state <= state;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_pkt_ctrl
// Directed bench for uart_rx_pkt_ctrl: a FIFO model feeds hand-written byte
// sequences and a monitor records delivered payload bytes and result pulses.
// Checksum bytes are chosen so LEN + payload + CSUM totals 0 mod 256
// (e.g. 03+11+22+33 = 69, so CSUM = 97).
// -----------------------------------------------------------------------------
module tb_uart_rx_pkt_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_rdy;
    logic [7:0] rx_data = 8'h00;
    logic       next_rx;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_ready = 1'b1;
    logic       pkt_last;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;

    int tests_run = 0;
    int failed    = 0;

    // FIFO model: written by the stimulus, read by the pop process.
    logic [7:0] mem [0:511];
    int wr_ptr = 0;
    int rd_ptr = 0;

    // Monitor state.
    logic [8:0] got [$];
    int  ok_cnt = 0;
    int  err_cnt = 0;
    int  both_cnt = 0;
    int  long_pulse = 0;
    logic prev_ok = 1'b0;

    int ok_base, err_base, got_base, bad;

    uart_rx_pkt_ctrl #(
        .SOF_BYTE (8'hA5),
        .MAX_LEN  (64)
`ifdef UART_RX_PKT_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .next_rx   (next_rx),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_last  (pkt_last),
        .pkt_ok    (pkt_ok),
        .pkt_err   (pkt_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign rx_rdy = (wr_ptr != rd_ptr);

    // Pop on the strobe; data is then stable through the capture edge.
    always @(negedge clk) begin
        if (next_rx === 1'b1) begin
            rx_data = mem[rd_ptr[8:0]];
            rd_ptr  = rd_ptr + 1;
        end
    end

    // Record accepted payload bytes and result pulses.
    always @(negedge clk) begin
        if (pkt_valid === 1'b1 && pkt_ready === 1'b1) got.push_back({pkt_last, pkt_data});
        if (pkt_ok === 1'b1) ok_cnt = ok_cnt + 1;
        if (pkt_err === 1'b1) err_cnt = err_cnt + 1;
        if (pkt_ok === 1'b1 && pkt_err === 1'b1) both_cnt = both_cnt + 1;
        if (pkt_ok === 1'b1 && prev_ok === 1'b1) long_pulse = long_pulse + 1;
        prev_ok = pkt_ok;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[8:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic mark();
        ok_base  = ok_cnt;
        err_base = err_cnt;
        got_base = got.size();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int idle = 0;
        int n = 0;
        while (idle < 3 && n < budget) begin
            @(negedge clk);
            n++;
            if (wr_ptr == rd_ptr && !next_rx && !busy && !pkt_valid) idle++;
            else idle = 0;
        end
        chk(tag, 32'(idle >= 3), 32'd1);
    endtask

    task automatic wait_got(input string tag, input int cnt, input int budget);
        int n = 0;
        while (got.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(got.size() >= cnt), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (pkt_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(pkt_valid), 32'd1);
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got.size()) return 32'(got[i]);
        return 32'hFFFF_FFFF;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_outputs",
            32'({next_rx, pkt_valid, pkt_last, pkt_ok, pkt_err, busy, err_code, pkt_data}), 32'd0);
        reset = 1'b0;

        // 1: good frame, consumer always ready.
        mark();
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h97);
        wait_idle("t1_idle", 200);
        chk("t1_ok",      32'(ok_cnt - ok_base), 32'd1);
        chk("t1_err",     32'(err_cnt - err_base), 32'd0);
        chk("t1_count",   32'(got.size() - got_base), 32'd3);
        chk("t1_byte0",   got_at(got_base), 32'h011);
        chk("t1_byte1",   got_at(got_base + 1), 32'h022);
        chk("t1_byte2",   got_at(got_base + 2), 32'h133);
        chk("t1_errcode", 32'(err_code), 32'd0);
        chk("t1_pulse1",  32'(long_pulse), 32'd0);

        // 2: same frame, bad checksum.
        mark();
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h00);
        wait_idle("t2_idle", 200);
        chk("t2_count",   32'(got.size() - got_base), 32'd3);
        chk("t2_err",     32'(err_cnt - err_base), 32'd1);
        chk("t2_ok",      32'(ok_cnt - ok_base), 32'd0);
        chk("t2_errcode", 32'(err_code), 32'd0);

        // 3: junk before SOF, zero-length frame.
        mark();
        push(8'h00); push(8'hFF); push(8'hA5); push(8'h00); push(8'h00);
        wait_idle("t3_idle", 200);
        chk("t3_ok",    32'(ok_cnt - ok_base), 32'd1);
        chk("t3_err",   32'(err_cnt - err_base), 32'd0);
        chk("t3_count", 32'(got.size() - got_base), 32'd0);

        // 4: LEN 0x41 > 64 aborts; following bytes are hunted again.
        mark();
        push(8'hA5); push(8'h41); push(8'hA5); push(8'h00); push(8'h00);
        wait_idle("t4_idle", 200);
        chk("t4_err",     32'(err_cnt - err_base), 32'd1);
        chk("t4_ok",      32'(ok_cnt - ok_base), 32'd1);
        chk("t4_errcode", 32'(err_code), 32'd1);
        chk("t4_count",   32'(got.size() - got_base), 32'd0);

        // LEN == MAX_LEN is legal: 64 bytes of 01, sum 40+40 = 80, CSUM 80.
        mark();
        push(8'hA5); push(8'h40);
        for (int i = 0; i < 64; i++) push(8'h01);
        push(8'h80);
        wait_idle("max_idle", 2000);
        chk("max_ok",    32'(ok_cnt - ok_base), 32'd1);
        chk("max_count", 32'(got.size() - got_base), 32'd64);
        chk("max_first", got_at(got_base), 32'h001);
        chk("max_last",  got_at(got_base + 63), 32'h101);

        // 5: backpressure on the second payload byte for 20 cycles.
        mark();
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h97);
        wait_got("t5_first", got_base + 1, 200);
        pkt_ready = 1'b0;
        wait_valid("t5_valid", 100);
        chk("t5_data", 32'(pkt_data), 32'h22);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (pkt_data !== 8'h22 || pkt_valid !== 1'b1 || next_rx !== 1'b0 || pkt_last !== 1'b0)
                bad++;
        end
        chk("t5_hold", 32'(bad), 32'd0);
        pkt_ready = 1'b1;
        wait_idle("t5_idle", 200);
        chk("t5_ok",    32'(ok_cnt - ok_base), 32'd1);
        chk("t5_count", 32'(got.size() - got_base), 32'd3);
        chk("t5_byte1", got_at(got_base + 1), 32'h022);

        // 6: stream stops mid-payload.
        mark();
        push(8'hA5); push(8'h02); push(8'h11);
        wait_got("t6_first", got_base + 1, 200);
`ifdef UART_RX_PKT_TIMEOUT_EN
        begin
            int n = 0;
            while (err_cnt == err_base && n < 60) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t6_timeout_err", 32'(err_cnt - err_base), 32'd1);
        chk("t6_errcode",     32'(err_code), 32'd2);
        chk("t6_busy",        32'(busy), 32'd0);
`else
        repeat (40) @(negedge clk);
        chk("t6_no_err", 32'(err_cnt - err_base), 32'd0);
        chk("t6_busy",   32'(busy), 32'd1);
`endif

        // Reset mid-PAYLOAD drops the frame silently.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mark();
        push(8'hA5); push(8'h02); push(8'h11);
        wait_got("rst_first", got_base + 1, 200);
        chk("rst_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy_after", 32'(busy), 32'd0);
        chk("rst_valid",      32'(pkt_valid), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_no_err", 32'(err_cnt - err_base), 32'd0);
        chk("ok_err_excl", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "time limit");
    end

endmodule
